// File: rtl/snake_engine_pkg.sv
// Shared encodings for the snake game: directions, engine FSM states and
// the opposite-direction helper used by the engine, renderer and button decoder.
package snake_engine_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirRight = 2'd1,
        DirDown  = 2'd2,
        DirLeft  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StCheck = 2'd2,
        StDead  = 2'd3
    } state_e;

    // Opposite directions differ only in bit 1 with this encoding.
    function automatic dir_e opposite_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Holds the direction to use on the next step, rejecting requests that would
// reverse the snake onto its own neck.
module snake_dir_filter
    import snake_engine_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  dir_e       dir,
    output dir_e       pending_dir
);

    dir_e req;
    logic accept;

    always_comb begin
        req    = dir_e'(dir_req);
        accept = enable && dir_valid && (req != opposite_dir(dir));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_dir <= DirRight;
        end else if (accept) begin
            pending_dir <= req;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake state engine: segment array, direction, length, wall and self-collision
// detection, plus a registered segment read port for the renderer.
module snake_engine
    import snake_engine_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned COORD_W   = 6,
    parameter int unsigned LEN_W     = 6,
    parameter int unsigned START_X   = 10,
    parameter int unsigned START_Y   = 15,
    parameter int unsigned START_LEN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    input  logic               grow,
    input  logic [LEN_W-1:0]   rd_idx,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_valid,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [LEN_W-1:0]   length,
    output logic               busy,
    output logic               step_done,
    output logic               game_over,
    output logic               overrun
);

    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];

    state_e           state;
    dir_e             dir;
    dir_e             pending_dir;
    logic             pending_grow;
    logic [LEN_W-1:0] idx;

    logic [COORD_W-1:0] new_x;
    logic [COORD_W-1:0] new_y;
    logic               wall_hit;
    logic               body_hit;
    logic [IdxW-1:0]    idx_sel;
    logic [IdxW-1:0]    rd_sel;
    logic               rd_in_range;
    logic               can_grow;

    snake_dir_filter u_dir_filter (
        .clk        (clk),
        .reset      (reset),
        .enable     (state != StDead),
        .dir_valid  (dir_valid),
        .dir_req    (dir_req),
        .dir        (dir),
        .pending_dir(pending_dir)
    );

    // Next head and wall test, both derived from the pre-shift head.
    always_comb begin
        new_x    = seg_x[0];
        new_y    = seg_y[0];
        wall_hit = 1'b0;
        unique case (pending_dir)
            DirUp: begin
                wall_hit = (seg_y[0] == '0);
                new_y    = seg_y[0] - COORD_W'(1);
            end
            DirRight: begin
                wall_hit = (seg_x[0] == COORD_W'(GRID_W - 1));
                new_x    = seg_x[0] + COORD_W'(1);
            end
            DirDown: begin
                wall_hit = (seg_y[0] == COORD_W'(GRID_H - 1));
                new_y    = seg_y[0] + COORD_W'(1);
            end
            DirLeft: begin
                wall_hit = (seg_x[0] == '0);
                new_x    = seg_x[0] - COORD_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        idx_sel     = idx[IdxW-1:0];
        body_hit    = (idx < length) &&
                      (seg_x[0] == seg_x[idx_sel]) && (seg_y[0] == seg_y[idx_sel]);
        rd_sel      = rd_idx[IdxW-1:0];
        rd_in_range = (rd_idx < length);
        can_grow    = (length < LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            dir          <= DirRight;
            pending_grow <= 1'b0;
            length       <= LEN_W'(START_LEN);
            idx          <= '0;
            step_done    <= 1'b0;
            overrun      <= 1'b0;
            game_over    <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (i < int'(START_LEN)) begin
                    seg_x[i] <= COORD_W'(int'(START_X) - i);
                    seg_y[i] <= COORD_W'(START_Y);
                end else begin
                    seg_x[i] <= '0;
                    seg_y[i] <= '0;
                end
            end
        end else begin
            step_done <= 1'b0;
            overrun   <= 1'b0;
            if (tick && (state == StShift || state == StCheck)) begin
                overrun <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (tick) begin
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (wall_hit) begin
                        state     <= StDead;
                        game_over <= 1'b1;
                    end else begin
                        for (int i = 1; i < int'(MAX_LEN); i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0]     <= new_x;
                        seg_y[0]     <= new_y;
                        dir          <= pending_dir;
                        pending_grow <= 1'b0;
                        if (pending_grow && can_grow) begin
                            length <= length + LEN_W'(1);
                        end
                        idx   <= LEN_W'(1);
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (body_hit) begin
                        state     <= StDead;
                        game_over <= 1'b1;
                    end else if (idx == length - LEN_W'(1)) begin
                        state     <= StIdle;
                        step_done <= 1'b1;
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                StDead: begin
                    game_over <= 1'b1;
                end
                default: state <= StIdle;
            endcase

            // A grow arriving during SHIFT belongs to the following step.
            if (grow && state != StDead) begin
                pending_grow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else if (rd_in_range) begin
            rd_x     <= seg_x[rd_sel];
            rd_y     <= seg_y[rd_sel];
            rd_valid <= 1'b1;
        end else begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    assign busy   = (state != StIdle);

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: reset, stepping, direction filter, growth,
// saturation, wall death, self-collision, overrun and reset mid-step.
module tb_snake_engine;

    localparam int unsigned MAX_LEN   = 32;
    localparam int unsigned GRID_W    = 40;
    localparam int unsigned GRID_H    = 30;
    localparam int unsigned COORD_W   = 6;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned START_X   = 10;
    localparam int unsigned START_Y   = 15;
    localparam int unsigned START_LEN = 3;

    localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;

    logic               clk = 1'b0;
    logic               reset;
    logic               tick;
    logic               dir_valid;
    logic [1:0]         dir_req;
    logic               grow;
    logic [LEN_W-1:0]   rd_idx;
    logic [COORD_W-1:0] rd_x, rd_y, head_x, head_y;
    logic               rd_valid, busy, step_done, game_over, overrun;
    logic [LEN_W-1:0]   length;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    logic done;

    snake_engine #(
        .MAX_LEN  (MAX_LEN),
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .COORD_W  (COORD_W),
        .LEN_W    (LEN_W),
        .START_X  (START_X),
        .START_Y  (START_Y),
        .START_LEN(START_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .dir_valid(dir_valid),
        .dir_req  (dir_req),
        .grow     (grow),
        .rd_idx   (rd_idx),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_valid (rd_valid),
        .head_x   (head_x),
        .head_y   (head_y),
        .length   (length),
        .busy     (busy),
        .step_done(step_done),
        .game_over(game_over),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_req = RIGHT; grow = 1'b0; rd_idx = '0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_req   = d;
        cycle();
        dir_valid = 1'b0;
    endtask

    // Tick (optionally with grow), then wait a bounded number of cycles for
    // step_done or game_over; cyc counts clock edges since the tick edge.
    task automatic run_step(input logic with_grow, input int budget,
                            output int n, output logic saw_done);
        grow = with_grow;
        tick = 1'b1;
        cycle();
        tick = 1'b0; grow = 1'b0; dir_valid = 1'b0;
        n = 1;
        while (!step_done && !game_over && n < budget) begin
            cycle();
            n++;
        end
        saw_done = step_done;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (head_x !== 6'd10 || head_y !== 6'd15) begin
            n_err++;
            $display("FAIL reset_head: got (%0d,%0d) want (10,15)", head_x, head_y);
        end
        n_cmp++;
        if (length !== 6'd3 || busy !== 1'b0 || game_over !== 1'b0 || step_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got len=%0d busy=%b go=%b sd=%b want 3 0 0 0",
                     length, busy, game_over, step_done);
        end
        rd_idx = 6'd2;
        cycle();
        n_cmp++;
        if (rd_x !== 6'd8 || rd_y !== 6'd15 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rd2: got (%0d,%0d,v%b) want (8,15,v1)", rd_x, rd_y, rd_valid);
        end
        rd_idx = 6'd3;
        cycle();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_x !== 6'd0 || rd_y !== 6'd0) begin
            n_err++;
            $display("FAIL reset_rd3: got (%0d,%0d,v%b) want (0,0,v0)", rd_x, rd_y, rd_valid);
        end
    endtask

    task automatic test_step();
        rd_idx = 6'd0;
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || step_done !== 1'b0) begin
            n_err++;
            $display("FAIL step_c1: got busy=%b sd=%b want 1 0", busy, step_done);
        end
        cycle();
        n_cmp++;
        if (busy !== 1'b1 || rd_x !== 6'd10) begin
            n_err++;
            $display("FAIL step_c2_preshift_read: got busy=%b rd_x=%0d want 1 10", busy, rd_x);
        end
        cycle();
        n_cmp++;
        if (busy !== 1'b1 || step_done !== 1'b0 || rd_x !== 6'd11) begin
            n_err++;
            $display("FAIL step_c3: got busy=%b sd=%b rd_x=%0d want 1 0 11", busy, step_done, rd_x);
        end
        cycle();
        n_cmp++;
        if (busy !== 1'b0 || step_done !== 1'b1) begin
            n_err++;
            $display("FAIL step_c4_done: got busy=%b sd=%b want 0 1", busy, step_done);
        end
        n_cmp++;
        if (head_x !== 6'd11 || head_y !== 6'd15 || length !== 6'd3) begin
            n_err++;
            $display("FAIL step_head: got (%0d,%0d) len=%0d want (11,15) 3", head_x, head_y, length);
        end
        rd_idx = 6'd2;
        cycle();
        n_cmp++;
        if (rd_x !== 6'd9 || rd_y !== 6'd15 || step_done !== 1'b0) begin
            n_err++;
            $display("FAIL step_seg2: got (%0d,%0d) sd=%b want (9,15) 0", rd_x, rd_y, step_done);
        end
    endtask

    task automatic test_reverse();
        set_dir(LEFT);
        run_step(1'b0, 40, cyc, done);
        n_cmp++;
        if (!done || cyc != 4 || head_x !== 6'd12 || head_y !== 6'd15) begin
            n_err++;
            $display("FAIL reverse_ignored: got done=%b cyc=%0d (%0d,%0d) want 1 4 (12,15)",
                     done, cyc, head_x, head_y);
        end
        // Request in the same cycle as tick applies to that step.
        dir_valid = 1'b1;
        dir_req   = UP;
        run_step(1'b0, 40, cyc, done);
        n_cmp++;
        if (!done || head_x !== 6'd12 || head_y !== 6'd14) begin
            n_err++;
            $display("FAIL turn_up: got done=%b (%0d,%0d) want 1 (12,14)", done, head_x, head_y);
        end
    endtask

    task automatic test_grow();
        run_step(1'b1, 40, cyc, done);
        n_cmp++;
        if (!done || cyc != 5 || length !== 6'd4 || head_x !== 6'd12 || head_y !== 6'd13) begin
            n_err++;
            $display("FAIL grow_step: got done=%b cyc=%0d len=%0d (%0d,%0d) want 1 5 4 (12,13)",
                     done, cyc, length, head_x, head_y);
        end
        rd_idx = 6'd3;
        cycle();
        n_cmp++;
        if (rd_x !== 6'd11 || rd_y !== 6'd15 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL grow_tail: got (%0d,%0d,v%b) want (11,15,v1)", rd_x, rd_y, rd_valid);
        end
    endtask

    task automatic test_saturate_and_wall();
        logic all_done;
        apply_reset();
        all_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            run_step(1'b1, 40, cyc, done);
            all_done &= done;
        end
        n_cmp++;
        if (!all_done || head_x !== 6'd30 || head_y !== 6'd15 || length !== 6'd23) begin
            n_err++;
            $display("FAIL grow_run: got done=%b (%0d,%0d) len=%0d want 1 (30,15) 23",
                     all_done, head_x, head_y, length);
        end
        set_dir(DOWN);
        for (int k = 0; k < 9; k++) begin
            run_step(1'b1, 40, cyc, done);
            all_done &= done;
        end
        n_cmp++;
        if (!all_done || head_y !== 6'd24 || length !== 6'd32) begin
            n_err++;
            $display("FAIL grow_to_max: got done=%b y=%0d len=%0d want 1 24 32",
                     all_done, head_y, length);
        end
        run_step(1'b1, 40, cyc, done);
        n_cmp++;
        if (!done || cyc != 33 || length !== 6'd32 || head_y !== 6'd25) begin
            n_err++;
            $display("FAIL grow_saturate: got done=%b cyc=%0d len=%0d y=%0d want 1 33 32 25",
                     done, cyc, length, head_y);
        end
        run_step(1'b0, 40, cyc, done);
        n_cmp++;
        if (!done || length !== 6'd32 || head_x !== 6'd30 || head_y !== 6'd26) begin
            n_err++;
            $display("FAIL post_saturate: got done=%b len=%0d (%0d,%0d) want 1 32 (30,26)",
                     done, length, head_x, head_y);
        end
        set_dir(RIGHT);
        for (int k = 0; k < 9; k++) begin
            run_step(1'b0, 40, cyc, done);
            all_done &= done;
        end
        n_cmp++;
        if (!all_done || head_x !== 6'd39 || head_y !== 6'd26 || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL reach_edge: got done=%b (%0d,%0d) go=%b want 1 (39,26) 0",
                     all_done, head_x, head_y, game_over);
        end
        run_step(1'b0, 40, cyc, done);
        n_cmp++;
        if (done || game_over !== 1'b1 || cyc != 2 || head_x !== 6'd39 || head_y !== 6'd26) begin
            n_err++;
            $display("FAIL wall_death: got done=%b go=%b cyc=%0d (%0d,%0d) want 0 1 2 (39,26)",
                     done, game_over, cyc, head_x, head_y);
        end
        rd_idx = 6'd1;
        cycle();
        n_cmp++;
        if (rd_x !== 6'd38 || rd_y !== 6'd26) begin
            n_err++;
            $display("FAIL wall_array_kept: got (%0d,%0d) want (38,26)", rd_x, rd_y);
        end
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || game_over !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL dead_tick: got ov=%b go=%b busy=%b want 0 1 1", overrun, game_over, busy);
        end
        for (int k = 0; k < 5; k++) cycle();
        n_cmp++;
        if (game_over !== 1'b1 || step_done !== 1'b0 || head_x !== 6'd39) begin
            n_err++;
            $display("FAIL dead_sticky: got go=%b sd=%b x=%0d want 1 0 39", game_over, step_done, head_x);
        end
        apply_reset();
        n_cmp++;
        if (game_over !== 1'b0 || busy !== 1'b0 || head_x !== 6'd10 || length !== 6'd3) begin
            n_err++;
            $display("FAIL dead_reset: got go=%b busy=%b x=%0d len=%0d want 0 0 10 3",
                     game_over, busy, head_x, length);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        run_step(1'b1, 40, cyc, done);
        run_step(1'b1, 40, cyc, done);
        n_cmp++;
        if (!done || length !== 6'd5 || head_x !== 6'd12 || head_y !== 6'd15) begin
            n_err++;
            $display("FAIL col_setup: got done=%b len=%0d (%0d,%0d) want 1 5 (12,15)",
                     done, length, head_x, head_y);
        end
        set_dir(UP);
        run_step(1'b0, 40, cyc, done);
        set_dir(LEFT);
        run_step(1'b0, 40, cyc, done);
        n_cmp++;
        if (!done || head_x !== 6'd11 || head_y !== 6'd14) begin
            n_err++;
            $display("FAIL col_turns: got done=%b (%0d,%0d) want 1 (11,14)", done, head_x, head_y);
        end
        set_dir(DOWN);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_pulse: got ov=%b busy=%b want 1 1", overrun, busy);
        end
        cycle();
        cycle();
        n_cmp++;
        if (overrun !== 1'b0 || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_once: got ov=%b go=%b want 0 0", overrun, game_over);
        end
        cycle();
        n_cmp++;
        if (game_over !== 1'b1 || step_done !== 1'b0 || head_x !== 6'd11 || head_y !== 6'd15) begin
            n_err++;
            $display("FAIL self_collision: got go=%b sd=%b (%0d,%0d) want 1 0 (11,15)",
                     game_over, step_done, head_x, head_y);
        end
    endtask

    task automatic test_reset_mid_check();
        apply_reset();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
        reset = 1'b1;
        #2;
        n_cmp++;
        if (busy !== 1'b0 || step_done !== 1'b0 || head_x !== 6'd10) begin
            n_err++;
            $display("FAIL mid_check_reset: got busy=%b sd=%b x=%0d want 0 0 10", busy, step_done, head_x);
        end
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (step_done !== 1'b0 || busy !== 1'b0 || length !== 6'd3) begin
            n_err++;
            $display("FAIL mid_check_no_done: got sd=%b busy=%b len=%0d want 0 0 3",
                     step_done, busy, length);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_req = RIGHT; grow = 1'b0; rd_idx = '0;
        test_reset();
        test_step();
        test_reverse();
        test_grow();
        test_saturate_and_wall();
        test_collision();
        test_reset_mid_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
